// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: detects enabled rising/falling edges per channel, holds one
// pending event per channel and presents them one at a time via a valid/ready
// handshake with round-robin channel selection.
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] a_i,
    input  logic [NUM_CH-1:0] rise_en_i,
    input  logic [NUM_CH-1:0] fall_en_i,
    input  logic              evt_ready_i,
    input  logic              ovf_clr_i,
    output logic              evt_valid_o,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic              evt_rise_o,
    output logic [NUM_CH-1:0] pend_o,
    output logic [NUM_CH-1:0] ovf_o
);

    typedef enum logic [0:0] {StIdle, StValid} state_t;

    state_t            state;
    state_t            state_next;
    logic [NUM_CH-1:0] a_ff;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] pend_next;
    logic [NUM_CH-1:0] ptype;
    logic [NUM_CH-1:0] ptype_next;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] ovf_next;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   win;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_rise;
    logic              win_found;
    logic              load;

    // Enabled edge detection against last cycle's level.
    always_comb begin
        rise = ~a_ff & a_i & rise_en_i;
        fall = a_ff & ~a_i & fall_en_i;
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!win_found && pend[(int'(last_grant) + i) % NUM_CH]) begin
                win       = CH_W'((int'(last_grant) + i) % NUM_CH);
                win_found = 1'b1;
            end
        end
        // The output register can take a new event when empty or being drained.
        load = win_found && (state == StIdle || evt_ready_i);
    end

    // Pending slot and overflow update; a new edge on the channel being loaded refills it.
    always_comb begin
        pend_next  = pend;
        ptype_next = ptype;
        ovf_next   = ovf_clr_i ? '0 : ovf;
        for (int c = 0; c < NUM_CH; c++) begin
            if (load && win == CH_W'(c)) begin
                pend_next[c] = 1'b0;
            end
            if (rise[c] || fall[c]) begin
                if (!pend[c] || (load && win == CH_W'(c))) begin
                    pend_next[c]  = 1'b1;
                    ptype_next[c] = rise[c];
                end else begin
                    ovf_next[c] = 1'b1;
                end
            end
        end
    end

    // Handshake FSM next state.
    always_comb begin
        state_next = state;
        unique case (state)
            StIdle:  if (load) state_next = StValid;
            StValid: if (evt_ready_i && !load) state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    // State, pending slots and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            a_ff       <= '0;
            pend       <= '0;
            ptype      <= '0;
            ovf        <= '0;
            evt_ch     <= '0;
            evt_rise   <= 1'b0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            state <= state_next;
            a_ff  <= a_i;
            pend  <= pend_next;
            ptype <= ptype_next;
            ovf   <= ovf_next;
            if (load) begin
                evt_ch     <= win;
                evt_rise   <= ptype[win];
                last_grant <= win;
            end
        end
    end

    assign evt_valid_o = (state == StValid);
    assign evt_ch_o    = evt_ch;
    assign evt_rise_o  = evt_rise;
    assign pend_o      = pend;
    assign ovf_o       = ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: a per-channel event model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] a_i = '0;
    logic [NUM_CH-1:0] rise_en_i = '1;
    logic [NUM_CH-1:0] fall_en_i = '1;
    logic              evt_ready_i = 1'b1;
    logic              ovf_clr_i = 1'b0;
    logic              evt_valid_o;
    logic [CH_W-1:0]   evt_ch_o;
    logic              evt_rise_o;
    logic [NUM_CH-1:0] pend_o;
    logic [NUM_CH-1:0] ovf_o;

    int passed = 0;
    int total  = 0;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_i        (a_i),
        .rise_en_i  (rise_en_i),
        .fall_en_i  (fall_en_i),
        .evt_ready_i(evt_ready_i),
        .ovf_clr_i  (ovf_clr_i),
        .evt_valid_o(evt_valid_o),
        .evt_ch_o   (evt_ch_o),
        .evt_rise_o (evt_rise_o),
        .pend_o     (pend_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Model state: per-channel previous level, pending event (type) and overflow;
    // the presented event and the channel granted most recently.
    bit [NUM_CH-1:0] m_prev = '0;
    bit [NUM_CH-1:0] m_pend = '0;
    bit [NUM_CH-1:0] m_type = '0;
    bit [NUM_CH-1:0] m_ovf  = '0;
    bit              m_valid = 1'b0;
    int              m_ch = 0;
    bit              m_rise = 1'b0;
    int              m_last = NUM_CH - 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev = '0; m_pend = '0; m_type = '0; m_ovf = '0;
            m_valid = 1'b0; m_ch = 0; m_rise = 1'b0; m_last = NUM_CH - 1;
        end else begin
            bit              taking;
            int              pick;
            bit [NUM_CH-1:0] np, nt, no;
            pick = -1;
            for (int k = 1; k <= NUM_CH; k++)
                if (pick < 0 && m_pend[(m_last + k) % NUM_CH]) pick = (m_last + k) % NUM_CH;
            taking = (pick >= 0) && (!m_valid || evt_ready_i);
            np = m_pend; nt = m_type; no = ovf_clr_i ? '0 : m_ovf;
            for (int c = 0; c < NUM_CH; c++) begin
                bit r, f, granted;
                r = !m_prev[c] && a_i[c] && rise_en_i[c];
                f = m_prev[c] && !a_i[c] && fall_en_i[c];
                granted = taking && pick == c;
                if (granted) np[c] = 1'b0;
                if (r || f) begin
                    if (!m_pend[c] || granted) begin np[c] = 1'b1; nt[c] = r; end
                    else no[c] = 1'b1;
                end
            end
            if (taking) begin
                m_valid = 1'b1; m_ch = pick; m_rise = m_type[pick]; m_last = pick;
            end else if (evt_ready_i) begin
                m_valid = 1'b0;
            end
            m_pend = np; m_type = nt; m_ovf = no; m_prev = a_i;
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("model_valid", 32'(evt_valid_o), 32'(m_valid));
        chk("model_ch", 32'(evt_ch_o), 32'(m_ch));
        chk("model_rise", 32'(evt_rise_o), 32'(m_rise));
        chk("model_pend", 32'(pend_o), 32'(m_pend));
        chk("model_ovf", 32'(ovf_o), 32'(m_ovf));
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    int grants[8];

    initial begin
        reset = 1'b1;
        cyc(2);
        chk("reset_valid", 32'(evt_valid_o), 0);
        chk("reset_ch", 32'(evt_ch_o), 0);
        chk("reset_rise", 32'(evt_rise_o), 0);
        chk("reset_pend", 32'(pend_o), 0);
        chk("reset_ovf", 32'(ovf_o), 0);
        reset = 1'b0;
        cyc(2);

        // Single rise on ch2 with two-cycle latency to valid.
        a_i = 4'b0100;
        cyc(1);
        chk("single_pend", 32'(pend_o), 32'b0100);
        chk("single_valid_early", 32'(evt_valid_o), 0);
        cyc(1);
        chk("single_valid", 32'(evt_valid_o), 1);
        chk("single_ch", 32'(evt_ch_o), 2);
        chk("single_rise", 32'(evt_rise_o), 1);
        cyc(1);
        chk("single_valid_drop", 32'(evt_valid_o), 0);

        // Four simultaneous rises drain on consecutive cycles in channel order.
        a_i = '0;
        do_reset();
        a_i = 4'b1111;
        cyc(1);
        chk("simul_pend", 32'(pend_o), 32'b1111);
        for (int i = 0; i < NUM_CH; i++) begin
            cyc(1);
            chk("simul_valid", 32'(evt_valid_o), 1);
            chk("simul_ch", 32'(evt_ch_o), 32'(i));
            chk("simul_rise", 32'(evt_rise_o), 1);
        end
        cyc(1);
        chk("simul_idle", 32'(evt_valid_o), 0);
        chk("simul_ovf", 32'(ovf_o), 0);

        // Backpressure: rise presented, fall pends, third edge overflows, clear.
        a_i = '0;
        evt_ready_i = 1'b0;
        do_reset();
        a_i = 4'b0010;
        cyc(2);
        chk("bp_ch", 32'(evt_ch_o), 1);
        chk("bp_pend_free", 32'(pend_o), 0);
        a_i = 4'b0000;
        cyc(1);
        chk("bp_fall_pend", 32'(pend_o), 32'b0010);
        chk("bp_hold_rise", 32'(evt_rise_o), 1);
        cyc(1);
        a_i = 4'b0010;
        cyc(1);
        chk("bp_ovf", 32'(ovf_o), 32'b0010);
        chk("bp_hold_ch", 32'(evt_ch_o), 1);
        ovf_clr_i = 1'b1;
        cyc(1);
        chk("bp_ovf_clr", 32'(ovf_o), 0);
        ovf_clr_i = 1'b0;
        evt_ready_i = 1'b1;
        cyc(1);
        chk("bp_next_valid", 32'(evt_valid_o), 1);
        chk("bp_next_fall", 32'(evt_rise_o), 0);
        cyc(1);
        chk("bp_drained", 32'(evt_valid_o), 0);

        // Fairness: ch0 and ch3 toggling every cycle alternate grants.
        a_i = '0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_i = a_i ^ 4'b1001;
            cyc(1);
            grants[i] = evt_valid_o ? int'(evt_ch_o) : -1;
        end
        chk("fair_g0", 32'(grants[1]), 0);
        chk("fair_g1", 32'(grants[2]), 3);
        chk("fair_g2", 32'(grants[3]), 0);
        chk("fair_g3", 32'(grants[4]), 3);
        cyc(6);

        // Disabled falling edge is discarded but the level history still tracks.
        a_i = '0;
        fall_en_i = '0;
        do_reset();
        a_i = 4'b0001;
        cyc(3);
        a_i = 4'b0000;
        cyc(1);
        chk("en_no_pend", 32'(pend_o), 0);
        cyc(1);
        chk("en_no_valid", 32'(evt_valid_o), 0);
        chk("en_no_ovf", 32'(ovf_o), 0);
        a_i = 4'b0001;
        cyc(1);
        chk("en_follow", 32'(pend_o), 32'b0001);
        cyc(3);
        fall_en_i = '1;

        // Reset while an event is presented with another pending.
        a_i = '0;
        evt_ready_i = 1'b0;
        do_reset();
        a_i = 4'b0011;
        cyc(2);
        chk("rst_pre_valid", 32'(evt_valid_o), 1);
        chk("rst_pre_pend", 32'(pend_o), 32'b0010);
        reset = 1'b1;
        a_i = 4'b0110;
        cyc(1);
        chk("rst_valid", 32'(evt_valid_o), 0);
        chk("rst_pend", 32'(pend_o), 0);
        chk("rst_ovf", 32'(ovf_o), 0);
        reset = 1'b0;
        cyc(1);
        chk("rst_rel_pend", 32'(pend_o), 32'b0110);
        cyc(1);
        chk("rst_first_ch", 32'(evt_ch_o), 1);
        evt_ready_i = 1'b1;
        cyc(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter CH_W, default $clog2(NUM_CH), width of evt_ch_o.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port a_i  input  NUM_CH  level inputs, one per channel, already synchronous to clk.
REQ-006 SHALL have port rise_en_i  input  NUM_CH  per-channel rising-edge enable.
REQ-007 SHALL have port fall_en_i  input  NUM_CH  per-channel falling-edge enable.
REQ-008 SHALL have port evt_ready_i  input  1  consumer ready.
REQ-009 SHALL have port ovf_clr_i  input  1  single-cycle pulse clearing all overflow flags.
REQ-010 SHALL have port evt_valid_o  output  1  event available.
REQ-011 SHALL have port evt_ch_o  output  CH_W  channel index of presented event.
REQ-012 SHALL have port evt_rise_o  output  1  1 = rising edge, 0 = falling edge.
REQ-013 SHALL have port pend_o  output  NUM_CH  per-channel pending flag.
REQ-014 SHALL have port ovf_o  output  NUM_CH  per-channel sticky overflow flag.

Function
REQ-015 SHALL register a_i per channel (a_ff); rise[c] = ~a_ff[c] & a_i[c] & rise_en_i[c]; fall[c] = a_ff[c] & ~a_i[c] & fall_en_i[c].
REQ-016 SHALL update a_ff every cycle regardless of enables; disabled edges SHALL be discarded with no pending/overflow effect.
REQ-017 SHALL hold per channel one pending slot (pend flag + type bit); detected edge with slot free sets pend and stores type on the next clock edge.
REQ-018 SHALL, on a detected edge while pend[c]=1 and c not being loaded this cycle, drop the new edge, keep the old type, set ovf_o[c].
REQ-019 SHALL, when channel c is loaded into the output register in the same cycle it detects a new edge, set pend[c] with the new type (set wins over clear, no overflow).
REQ-020 SHALL implement FSM IDLE/VALID; evt_valid_o = 1 exactly in VALID.
REQ-021 IDLE: if any pend set, SHALL load the round-robin winner (channel, type) into output regs, clear its pend, go VALID; else stay IDLE.
REQ-022 VALID: SHALL hold evt_ch_o/evt_rise_o stable while evt_ready_i=0.
REQ-023 VALID with evt_ready_i=1: SHALL load next winner and stay VALID if any pend set (back-to-back, no bubble), else go IDLE.
REQ-024 Round-robin SHALL search from last_grant+1 upward, wrapping modulo NUM_CH; last_grant updates on each load.
REQ-025 Latency: edge present on a_i in cycle N -> pend_o set in N+1 -> evt_valid_o in N+2 when IDLE and uncontested.
REQ-026 SHALL give ovf_clr_i priority below a same-cycle new overflow (set wins); otherwise clear all ovf_o.
REQ-027 evt_ch_o/evt_rise_o SHALL be don't-care-free: hold last loaded values in IDLE.

Reset
REQ-028 On reset SHALL force: a_ff=0, pend=0, types=0, ovf_o=0, FSM=IDLE, evt_valid_o=0, evt_ch_o=0, evt_rise_o=0, last_grant=NUM_CH-1 (channel 0 first priority).
REQ-029 Reset mid-handshake SHALL discard the presented and all pending events; a_i high at reset release SHALL produce a rising event only if rise_en_i set (a_ff=0).

Verification
REQ-030 Single rise: en all, ready=1, a_i[2] 0->1 at cycle N -> pend_o[2]=1 at N+1, evt_valid_o=1, evt_ch_o=2, evt_rise_o=1 at N+2, valid low at N+3.
REQ-031 Simultaneous: a_i 0000->1111 in one cycle, ready=1 -> events ch0,1,2,3 on four consecutive cycles, all rise, no ovf.
REQ-032 Backpressure: ready=0, ch1 rise then ch1 fall two cycles later -> ch1 presented stable; fall goes to pend (slot freed on load), third edge (rise) sets ovf_o[1]=1; ovf_clr_i clears it.
REQ-033 Fairness: ch0 and ch3 toggled every cycle, ready=1 -> grants alternate 0,3,0,3; neither starved.
REQ-034 Enables: fall_en_i=0, a_i[0] 1->0 -> no pend, no event, no ovf; a_ff still follows.
REQ-035 Reset mid-VALID with pend set -> next cycle evt_valid_o=0, pend_o=0, ovf_o=0; first post-reset grant goes to lowest pending channel.
